// File: rtl/spi_register_target_pkg.sv
// -----------------------------------------------------------------------------
// spi_register_target_pkg
//   Shared constants and the frame FSM encoding for the SPI register target.
//   CMD_WRITE_BIT : bit of the command byte that selects write (1) / read (0)
//   ADDR_W        : register address width (7 bits, wraps 127 -> 0)
//   DATA_W        : register / SPI byte width
//   state_t       : frame FSM states
// -----------------------------------------------------------------------------
package spi_register_target_pkg;

    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_W        = 7;
    localparam int DATA_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/spi_register_target_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
//   Brings one asynchronous SPI pin into the clk domain through a 2-FF
//   synchroniser and derives single-cycle rise/fall events from a history FF.
//   Ports:
//     clk, rst : system clock, asynchronous active-high reset
//     i_d      : raw pin
//     o_q      : synchronised level
//     o_rise   : one-cycle pulse on a synchronised 0->1 transition
//     o_fall   : one-cycle pulse on a synchronised 1->0 transition
//   All flops reset to 0, so a line that is already low when reset is
//   released produces no fall event.
// -----------------------------------------------------------------------------
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_q    = r_sync;
    assign o_rise = r_sync & ~r_hist;
    assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/spi_register_target.sv
// -----------------------------------------------------------------------------
// spi_register_target
//   SPI mode-0 target exposing a bank of NREGS 8-bit registers. Frames are a
//   command byte (bit7 = write, bits 6:0 = start address) followed by data
//   bytes with address auto-increment. SPI pins are oversampled by clk
//   (clk must be at least 8x SCK).
//   Parameters:
//     NREGS     : implemented registers (1..128); higher addresses read 0
//                 and ignore writes
//     RESET_VAL : reset value of every register
//   Ports:
//     clk, rst          : system clock, asynchronous active-high reset
//     spi_sck/cs/mosi   : SPI inputs (SCK idle low, CS active low)
//     spi_miso          : serial data out, forced 0 when not selected
//     spi_miso_oe       : high while a frame is selected
//     regs              : flat register contents, reg k at [8k+7:8k]
//     wr_stb            : one-cycle pulse per completed in-range write
//     wr_addr / wr_data : address / data of the strobed write
// -----------------------------------------------------------------------------
module spi_register_target
    import spi_register_target_pkg::*;
#(
    parameter int          NREGS     = 16,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [NREGS*8-1:0]    regs,
    output logic                  wr_stb,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    // Synchronised pin events
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;
    logic w_sck_level_unused;
    logic w_cs_level_unused;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    spi_sync_edge u_sync_sck (
        .clk    (clk),
        .rst    (rst),
        .i_d    (spi_sck),
        .o_q    (w_sck_level_unused),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .i_d    (spi_cs),
        .o_q    (w_cs_level_unused),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .i_d    (spi_mosi),
        .o_q    (w_mosi),
        .o_rise (w_mosi_rise_unused),
        .o_fall (w_mosi_fall_unused)
    );

    // State and datapath registers
    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_bitcnt;
    logic [6:0]          r_shift_in;
    logic [DATA_W-1:0]   r_shift_out;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_regs [NREGS];
    logic                r_wr_stb;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NREGS;
    endfunction

    // Unimplemented addresses read back as zero.
    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        return in_range(a) ? r_regs[a[IDX_W-1:0]] : '0;
    endfunction

    logic                w_active;
    logic                w_byte_done;
    logic [DATA_W-1:0]   w_byte;
    logic [ADDR_W-1:0]   w_addr_next;

    assign w_active    = (r_state != ST_IDLE);
    // A CS rise in the same cycle as the 8th SCK rise discards the byte.
    assign w_byte_done = w_active & w_sck_rise & (r_bitcnt == 3'd7) & ~w_cs_rise;
    assign w_byte      = {r_shift_in, w_mosi};
    assign w_addr_next = r_addr + 7'd1;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_cs_fall) w_next_state = ST_CMD;
            ST_CMD: begin
                if (w_cs_rise)        w_next_state = ST_IDLE;
                else if (w_byte_done) w_next_state = ST_DATA;
            end
            ST_DATA: if (w_cs_rise) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        spi_miso_oe = w_active;
        spi_miso    = w_active & r_shift_out[DATA_W-1];
    end

    // Datapath: bit counter, shifters, address, register bank, write strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt    <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= RESET_VAL;
            end
        end else begin
            r_wr_stb <= 1'b0;

            if (!w_active || w_cs_rise) begin
                r_bitcnt <= '0;
            end else if (w_sck_rise) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end

            if (w_active && w_sck_rise) begin
                r_shift_in <= w_byte[6:0];
            end

            if (r_state == ST_CMD && w_byte_done) begin
                r_rw        <= w_byte[CMD_WRITE_BIT];
                r_addr      <= w_byte[ADDR_W-1:0];
                r_shift_out <= rd_val(w_byte[ADDR_W-1:0]);
            end else if (r_state == ST_DATA && w_byte_done) begin
                if (r_rw && in_range(r_addr)) begin
                    r_regs[r_addr[IDX_W-1:0]] <= w_byte;
                    r_wr_stb                  <= 1'b1;
                    r_wr_addr                 <= r_addr;
                    r_wr_data                 <= w_byte;
                end
                r_addr      <= w_addr_next;
                r_shift_out <= rd_val(w_addr_next);
            end else if (r_state == ST_DATA && w_sck_fall && r_bitcnt != 3'd0) begin
                // The fall right after a load (bitcnt == 0) must keep the MSB
                // on the line for the first rise of the next byte.
                r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

    for (genvar k = 0; k < NREGS; k++) begin : g_regs
        assign regs[8*k +: 8] = r_regs[k];
    end

endmodule
